audio_freq_detector: RTL
========================

// Module: audio_freq_detector
// PURPOSE
//  Receive-side counterpart of the square-wave tone generator. Pops ADC samples from Audio_Controller,
//  detects zero crossings of the left channel with hysteresis, and times the half-period in CLOCK_50 cycles.
//  Converts the half-period back to the 4-bit frequency code (half-period = {code,15'd3000}+1 cycles),
//  debounces it, and drives the state-machine / display logic with the recovered code.
// PARAMETERS
//  HYST        32'sd2_000_000  crossing threshold magnitude (signed sample units)
//  TIMEOUT     20'd1_000_000   cycles without a crossing before declaring silence
//  STABLE_CNT  3               consecutive identical raw codes required before freq_code updates
//  OFFSET      3001            half-period cycles corresponding to code 0
// PORTS
//  CLOCK_50               in   1   system clock, 50 MHz
//  reset                  in   1   synchronous, active-low
//  audio_in_available     in   1   Audio_Controller: sample ready in FIFO
//  left_channel_audio_in  in   32  Audio_Controller: signed two's-complement sample
//  read_audio_in          out  1   pop strobe to Audio_Controller
//  freq_code              out  4   recovered frequency code (0 = silence)
//  freq_valid             out  1   1-cycle pulse when freq_code changes
//  tone_present           out  1   high while crossings arrive within TIMEOUT
//  crossing_pulse         out  1   1-cycle pulse per qualified crossing (debug LED)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): freq_code=0, freq_valid=0, tone_present=0, crossing_pulse=0,
//    read_audio_in=0, polarity=UNK, period counter=0, stable counter=0. Mid-measurement reset discards all.
//  - Handshake: read_audio_in = audio_in_available & reset (combinational); sample accepted on the same
//    posedge where read_audio_in==1. One sample per accept; no buffering inside the block.
//  - Polarity FSM (evaluated on accepted samples only; signed compare):
//    UNK: s > +HYST -> POS; s < -HYST -> NEG; else stay. No crossing reported.
//    POS: s < -HYST -> NEG, crossing. NEG: s > +HYST -> POS, crossing. |s| <= HYST: hold.
//  - Period counter: 20-bit, +1 every cycle, saturates at TIMEOUT. On crossing, hp = counter value
//    (before clear), counter cleared to 0 in the same cycle.
//  - Arming: first crossing after reset, UNK or timeout only clears counter; no measurement.
//  - Conversion: raw = (hp + 32768/2 - OFFSET) >> 15, 21-bit intermediate, saturated to 15.
//    Example: hp = 5*32768+3001 = 166841 -> raw 5. Rounds to nearest code.
//  - Debounce: raw == last_raw -> stable++ (saturating), else stable=1, last_raw=raw.
//    When stable reaches STABLE_CNT and raw != freq_code: freq_code<=raw, freq_valid pulses 1 cycle.
//  - tone_present set on first measured hp; crossing_pulse = registered crossing (1 cycle late).
//  - Timeout: counter == TIMEOUT -> polarity=UNK, tone_present=0, stable=0; if freq_code!=0 then
//    freq_code<=0 with freq_valid pulse. Crossing and timeout in same cycle: crossing wins.
//  - No accepted sample in a cycle: FSM holds, counter still advances.
// CONFIGURATION
//  FREQ_DET_FULLPERIOD_EN defined: measure rising-to-rising only (NEG->POS crossings); hp = period>>1.
//    Immune to DC offset/duty-cycle skew; TIMEOUT applies to full period; arming needs one rising edge.
//  Undefined: measure every crossing (half-period) as above.
// TESTING
//  1. Square wave +/-10_000_000, half-period 166841 cycles -> freq_code=5, freq_valid once, after
//     1 arm + 3 measured crossings; tone_present=1.
//  2. Step code 5 -> 12 (hp 396217) -> freq_code holds 5 for 2 crossings, becomes 12 on 3rd; one pulse.
//  3. Samples within +/-HYST (e.g. +/-1_000_000) -> no crossing_pulse; after 1_000_000 cycles
//     tone_present=0, freq_code=0, freq_valid pulse.
//  4. hp=600000 (beyond code 15) -> freq_code=15; hp=3001 -> freq_code=0 with tone_present=1.
//  5. audio_in_available=0 for 2000 cycles mid-tone -> FSM holds, counter keeps running; measured
//     code unchanged when samples resume before TIMEOUT.
//  6. reset low for 1 cycle mid-period -> all outputs 0 next cycle; next crossing only re-arms.

Source files
------------

// File: rtl/audio_freq_detector.sv
// audio_freq_detector: recovers the tone generator's 4-bit frequency code from ADC samples.
// Zero crossings of the left channel are detected with hysteresis. The time between crossings
// is converted back to a code, debounced, and presented on freq_code.
// Optional build macro FREQ_DET_FULLPERIOD_EN: time rising-to-rising crossings only and halve
// the result, which makes the measurement immune to DC offset and duty-cycle skew.
module audio_freq_detector #(
    parameter logic signed [31:0] HYST       = 32'sd2_000_000,
    parameter logic        [19:0] TIMEOUT    = 20'd1_000_000,
    parameter int unsigned        STABLE_CNT = 3,
    parameter int unsigned        OFFSET     = 3001,
    // log2 of the half-period cycles per code step
    parameter int unsigned        CODE_SHIFT = 15
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        audio_in_available,
    input  logic [31:0] left_channel_audio_in,
    output logic        read_audio_in,
    output logic [3:0]  freq_code,
    output logic        freq_valid,
    output logic        tone_present,
    output logic        crossing_pulse
);

    localparam int unsigned    SW         = $clog2(STABLE_CNT + 1);
    localparam logic [SW-1:0]  STABLE_MAX = SW'(STABLE_CNT);
    localparam logic [20:0]    HALF       = 21'(1) << (CODE_SHIFT - 1);
    localparam logic [20:0]    OFS        = 21'(OFFSET);

    typedef enum logic [1:0] {PolUnk, PolPos, PolNeg} pol_e;

    pol_e               r_pol;
    pol_e               w_pol_next;
    logic signed [31:0] w_sample;
    logic               w_accept;
    logic               w_above;
    logic               w_below;
    logic               w_rise;
    logic               w_fall;
    logic               w_cross;
    logic               w_leave_unk;
    logic               w_timeout;

    logic [19:0]        r_cnt;
    logic [19:0]        w_hp;
    logic [20:0]        w_sum;
    logic [20:0]        w_quot;
    logic [3:0]         w_raw;

    logic               r_armed;
    logic               w_armed_next;
    logic [SW-1:0]      r_stable;
    logic [SW-1:0]      w_stable_next;
    logic [3:0]         r_last_raw;
    logic [3:0]         w_last_next;
    logic [3:0]         r_freq_code;
    logic [3:0]         w_code_next;
    logic               r_freq_valid;
    logic               w_valid_next;
    logic               r_tone;
    logic               w_tone_next;
    logic               r_cross;

    // Pop strobe follows availability directly; reset masks it so nothing is consumed in reset.
    assign read_audio_in = audio_in_available & reset;
    assign w_accept      = read_audio_in;
    assign w_sample      = left_channel_audio_in;
    assign w_above       = w_sample > HYST;
    assign w_below       = w_sample < -HYST;
    assign w_leave_unk   = w_accept && (r_pol == PolUnk) && (w_above || w_below);
    // Leaving UNK restarts the counter, so it must also override a saturated timeout.
    assign w_timeout     = (r_cnt == TIMEOUT) && !w_cross && !w_leave_unk;

    // Polarity state register.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            r_pol <= PolUnk;
        end else begin
            r_pol <= w_pol_next;
        end
    end

    // Polarity next state: only accepted samples move it; timeout drops back to UNK.
    always_comb begin
        w_pol_next = r_pol;
        if (w_accept) begin
            unique case (r_pol)
                PolUnk: begin
                    if (w_above) begin
                        w_pol_next = PolPos;
                    end else if (w_below) begin
                        w_pol_next = PolNeg;
                    end
                end
                PolPos: if (w_below) w_pol_next = PolNeg;
                PolNeg: if (w_above) w_pol_next = PolPos;
                default: w_pol_next = PolUnk;
            endcase
        end
        if (w_timeout) begin
            w_pol_next = PolUnk;
        end
    end

    // Polarity outputs: crossing strobes decoded from the current state and sample.
    always_comb begin
        w_rise = w_accept && (r_pol == PolNeg) && w_above;
        w_fall = w_accept && (r_pol == PolPos) && w_below;
    end

`ifdef FREQ_DET_FULLPERIOD_EN
    assign w_cross = w_rise;
    assign w_hp    = r_cnt >> 1;
`else
    assign w_cross = w_rise | w_fall;
    assign w_hp    = r_cnt;
`endif

    // Cycle counter between qualified crossings, saturating at TIMEOUT.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_cross || w_leave_unk) begin
            r_cnt <= '0;
        end else if (r_cnt != TIMEOUT) begin
            r_cnt <= r_cnt + 20'd1;
        end
    end

    // Half-period to code, rounding to nearest and saturating at 15.
    always_comb begin
        w_sum  = {1'b0, w_hp} + HALF;
        w_quot = (w_sum - OFS) >> CODE_SHIFT;
        if (w_sum < OFS) begin
            w_raw = 4'd0;
        end else if (w_quot > 21'd15) begin
            w_raw = 4'd15;
        end else begin
            w_raw = w_quot[3:0];
        end
    end

    // Arming, debounce, tone tracking and timeout handling.
    always_comb begin
        w_armed_next  = r_armed;
        w_stable_next = r_stable;
        w_last_next   = r_last_raw;
        w_code_next   = r_freq_code;
        w_valid_next  = 1'b0;
        w_tone_next   = r_tone;
        if (w_cross) begin
            w_armed_next = 1'b1;
            // The first crossing after arming loss has no valid start point.
            if (r_armed) begin
                w_tone_next = 1'b1;
                if (w_raw == r_last_raw) begin
                    if (r_stable != STABLE_MAX) begin
                        w_stable_next = r_stable + SW'(1);
                    end
                end else begin
                    w_stable_next = SW'(1);
                    w_last_next   = w_raw;
                end
                if ((w_stable_next == STABLE_MAX) && (w_raw != r_freq_code)) begin
                    w_code_next  = w_raw;
                    w_valid_next = 1'b1;
                end
            end
        end else if (w_timeout) begin
            w_armed_next  = 1'b0;
            w_tone_next   = 1'b0;
            w_stable_next = '0;
            if (r_freq_code != 4'd0) begin
                w_code_next  = 4'd0;
                w_valid_next = 1'b1;
            end
        end
    end

    // Measurement and output registers.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            r_armed      <= 1'b0;
            r_stable     <= '0;
            r_last_raw   <= 4'd0;
            r_freq_code  <= 4'd0;
            r_freq_valid <= 1'b0;
            r_tone       <= 1'b0;
            r_cross      <= 1'b0;
        end else begin
            r_armed      <= w_armed_next;
            r_stable     <= w_stable_next;
            r_last_raw   <= w_last_next;
            r_freq_code  <= w_code_next;
            r_freq_valid <= w_valid_next;
            r_tone       <= w_tone_next;
            r_cross      <= w_cross;
        end
    end

    assign freq_code      = r_freq_code;
    assign freq_valid     = r_freq_valid;
    assign tone_present   = r_tone;
    assign crossing_pulse = r_cross;

endmodule
